// File: rtl/reg_file.sv
// reg_file: 32-entry architectural register file for the single-cycle CPU.
// It has two combinational read ports and one synchronous write port, and r0
// is hard-wired to zero. A debug dump engine streams r0..r31 out over a
// valid/ready handshake.
// Optional feature: define REG_FILE_BYPASS_EN to forward write data to a read
// port whose address matches the write address in the same cycle.
module reg_file #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ra1,
  output logic [WIDTH-1:0] rd1,
  input  logic [4:0]       ra2,
  output logic [WIDTH-1:0] rd2,
  input  logic             we,
  input  logic [4:0]       wa,
  input  logic [WIDTH-1:0] wd,
  input  logic             dump_start,
  output logic             dump_busy,
  output logic             dump_valid,
  input  logic             dump_ready,
  output logic [4:0]       dump_idx,
  output logic [WIDTH-1:0] dump_data
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } dump_state_t;

  // Entry 0 is cleared on reset and never written, so it always holds zero.
  logic [WIDTH-1:0] regs [0:31];

  dump_state_t      state, next_state;
  logic [4:0]       idx_q, next_idx;
  logic [WIDTH-1:0] data_q, next_data;
  logic [4:0]       succ_idx;
  logic             fwd1, fwd2;

  assign succ_idx = idx_q + 5'd1;

`ifdef REG_FILE_BYPASS_EN
  assign fwd1 = we && (wa != 5'd0) && (wa == ra1);
  assign fwd2 = we && (wa != 5'd0) && (wa == ra2);
`else
  assign fwd1 = 1'b0;
  assign fwd2 = 1'b0;
`endif

  // Register storage: reset r1..r31 to RESET_VAL and drop writes aimed at r0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= (i == 0) ? '0 : RESET_VAL;
      end
    end else if (we && (wa != 5'd0)) begin
      regs[wa] <= wd;
    end
  end

  // Read ports: r0 reads as zero, and a matching same-cycle write is forwarded when enabled.
  always_comb begin
    rd1 = (ra1 == 5'd0) ? '0 : regs[ra1];
    rd2 = (ra2 == 5'd0) ? '0 : regs[ra2];
    if (fwd1) rd1 = wd;
    if (fwd2) rd2 = wd;
  end

  // Dump engine state, beat index and held beat data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      idx_q  <= '0;
      data_q <= '0;
    end else begin
      state  <= next_state;
      idx_q  <= next_idx;
      data_q <= next_data;
    end
  end

  // Dump next-state logic. Beats are captured from stored values, never from forwarding.
  always_comb begin
    next_state = state;
    next_idx   = idx_q;
    next_data  = data_q;
    case (state)
      IDLE: begin
        if (dump_start) begin
          next_state = SEND;
          next_idx   = '0;
          next_data  = '0;
        end
      end
      SEND: begin
        if (dump_ready) begin
          if (idx_q == 5'd31) begin
            next_state = IDLE;
            next_idx   = '0;
            next_data  = '0;
          end else begin
            next_idx  = succ_idx;
            next_data = regs[succ_idx];
          end
        end
      end
      default: begin
        next_state = IDLE;
        next_idx   = '0;
        next_data  = '0;
      end
    endcase
  end

  assign dump_busy  = (state == SEND);
  assign dump_valid = (state == SEND);
  assign dump_idx   = idx_q;
  assign dump_data  = data_q;

endmodule

// File: doc/reg_file.md
# reg_file

Architectural register file for the single-cycle CPU: 32 registers of `WIDTH` bits, two combinational read ports, and one synchronous write port. The write port is addressed by the 5-bit destination selected upstream (rt or rd). A sequential debug dump engine streams all 32 registers out over a valid/ready handshake for board-level inspection.

## Interface
- `WIDTH`, default 32: register data width.
- `RESET_VAL`, default 0: value loaded into registers 1..31 on reset.

- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `ra1`  in  5  read port 1 address.
- `rd1`  out  WIDTH  read port 1 data, combinational.
- `ra2`  in  5  read port 2 address.
- `rd2`  out  WIDTH  read port 2 data, combinational.
- `we`  in  1  write enable.
- `wa`  in  5  write address (selected destination register).
- `wd`  in  WIDTH  write data.
- `dump_start`  in  1  starts a dump; ignored unless the engine is idle.
- `dump_busy`  out  1  high while a dump is in progress.
- `dump_valid`  out  1  dump beat present.
- `dump_ready`  in  1  consumer accepts the beat.
- `dump_idx`  out  5  register index of the current beat.
- `dump_data`  out  WIDTH  register value of the current beat.

## Operation
- Write: at the rising edge, if `we`=1 and `wa`!=0, reg[wa] <= wd. A write to r0 is discarded.
- Read: `rdN` = 0 when `raN`=0; otherwise reg[raN], combinational.
- Reset, asynchronous: r1..r31 <= RESET_VAL. r0 is always 0. Dump FSM goes to IDLE. `dump_busy`=0, `dump_valid`=0, `dump_idx`=0, `dump_data`=0.
- Dump FSM states:
  - IDLE: `dump_valid`=0, `dump_busy`=0. If `dump_start`=1, move to SEND with idx=0 and capture reg[0] (0).
  - SEND: `dump_valid`=1, `dump_busy`=1.
    - On `dump_valid` && `dump_ready`: if idx=31, go to IDLE. Otherwise idx <= idx+1 and `dump_data` <= stored reg[idx+1].
    - With `dump_ready`=0, `dump_idx` and `dump_data` hold stable.
- Beat capture uses the stored value before any write in the same cycle. A later write to an already-captured index does not alter the held beat.
- `dump_start` while busy is ignored. No queued restart.
- Register writes and reads remain fully functional during a dump.
- Index wraps only through IDLE. idx never increments past 31.

## Timing
- Write latency: 1 edge. Read latency: 0, combinational.
- `dump_start` sampled at edge E. From E: `dump_busy`=1, `dump_valid`=1, `dump_idx`=0.
- With `dump_ready` held high, one beat transfers per cycle: 32 beats on edges E+1..E+32. After E+32: `dump_busy`=0, `dump_valid`=0.
- `dump_start` high at E+32, on the final transfer edge, is ignored because the FSM is still in SEND at that edge.
- Reset asserted mid-dump: all dump outputs go to 0 immediately, without waiting for a clock edge. After reset releases, a new `dump_start` is required.

## Configuration
- `REG_FILE_BYPASS_EN` defined: if `we`=1, `wa`!=0 and `wa`=`raN`, then `rdN`=`wd` in the same cycle (write-through forwarding).
- `REG_FILE_BYPASS_EN` undefined: `rdN` returns the stored value. The new value becomes visible after the write edge.
- Dump capture never bypasses, with or without the macro.

## Test plan
- Reset with RESET_VAL=0: `rd1`/`rd2` read 0 for all 32 addresses. Dump outputs are 0 and `dump_busy`=0.
- Write 0xDEADBEEF to r5. Then `ra1`=5, `ra2`=0 -> `rd1`=0xDEADBEEF, `rd2`=0. Write 0x12345678 to r0 -> r0 still reads 0.
- Same-cycle write r7=0xA5A5A5A5 with `ra1`=7:
  - Macro defined: `rd1`=0xA5A5A5A5 before the edge.
  - Macro undefined: `rd1` shows the old value until after the edge.
- Preload rN=N*0x11. Pulse `dump_start` with `dump_ready` held 1 -> 32 consecutive beats with idx 0..31 and data N*0x11 (idx 0 -> 0). `dump_busy` drops after the 32nd transfer.
- Backpressure at idx 3:
  - Hold `dump_ready`=0 for 5 cycles and write r3=0xFFFFFFFF during the stall -> beat holds idx 3 and the original r3 data.
  - Release -> idx 4 follows.
  - `dump_start` pulsed during the stall -> no effect.
- Assert `reset` at idx 10 mid-dump -> `dump_valid`/`dump_busy` go to 0 immediately and registers return to RESET_VAL. A new dump after release starts at idx 0.
